// File: rtl/d_mem_line_responder.sv
// ---------------------------------------------------------------------------
// d_mem_line_responder : 128-bit line memory with fixed LATENCY and RDY pulse;
//   optional 32-bit word enables (BE port) when D_MEM_BE_EN is defined.
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module d_mem_line_responder #(
  parameter int    AWIDTH   = 10,
  parameter int    SIZE     = 1024,
  parameter int    LATENCY  = 4,
  parameter string INITFILE = ""
) (
  input  logic              CLK,
  input  logic              RSTn,
  input  logic              CSN,
  input  logic              WEN,
  input  logic [AWIDTH-1:0] ADDR,
  input  logic [127:0]      DI,
`ifdef D_MEM_BE_EN
  input  logic [3:0]        BE,
`endif
  output logic [127:0]      DOUT,
  output logic              RDY,
  output logic              BUSY
);

  localparam int                IW       = (SIZE > 1) ? $clog2(SIZE) : 1;
  localparam logic [3:0]        LAT_M1   = 4'(LATENCY - 1);
  localparam logic [AWIDTH:0]   SIZE_LIM = (AWIDTH + 1)'(SIZE);

  generate
    if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
      $error("d_mem_line_responder: LATENCY %0d outside 1..15", LATENCY);
    end
    if (SIZE < 1 || SIZE > (2 ** AWIDTH)) begin : g_bad_size
      $error("d_mem_line_responder: SIZE %0d does not fit AWIDTH %0d", SIZE, AWIDTH);
    end
    if (INITFILE != "") begin : g_preload_note
      $info("d_mem_line_responder: image %s is expected to be loaded into mem by the environment", INITFILE);
    end
  endgenerate

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_t;

  state_t              state;
  logic [3:0]          count;
  logic [AWIDTH-1:0]   req_addr;
  logic                req_wen;
  logic [127:0]        req_di;
  logic [3:0]          req_be;

  logic [127:0]        mem [0:SIZE-1];

  logic                in_range;
  logic [IW-1:0]       idx;
  logic                finish;
  logic                commit_wr;
  logic [3:0]          be_in;

`ifdef D_MEM_BE_EN
  assign be_in = BE;
`else
  assign be_in = 4'hF;
`endif

  assign in_range  = ({1'b0, req_addr} < SIZE_LIM);
  assign idx       = req_addr[IW-1:0];
  assign finish    = (state == S_BUSY) && (count == 4'd0);
  assign commit_wr = finish && !req_wen && in_range;
  assign BUSY      = (state == S_BUSY);

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state    <= S_IDLE;
      count    <= 4'd0;
      req_addr <= '0;
      req_wen  <= 1'b1;
      req_di   <= '0;
      req_be   <= 4'h0;
      DOUT     <= '0;
      RDY      <= 1'b0;
    end else begin
      RDY <= 1'b0;
      case (state)
        S_IDLE: begin
          if (!CSN) begin
            state    <= S_BUSY;
            count    <= LAT_M1;
            req_addr <= ADDR;
            req_wen  <= WEN;
            req_di   <= DI;
            req_be   <= be_in;
          end
        end
        S_BUSY: begin
          if (count == 4'd0) begin
            state <= S_IDLE;
            RDY   <= 1'b1;
            // Writes leave DOUT alone; out-of-range reads return zero.
            if (req_wen) begin
              DOUT <= in_range ? mem[idx] : '0;
            end
          end else begin
            count <= count - 4'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Array has no reset; it only changes on a completing in-range write.
  always_ff @(posedge CLK) begin
    if (commit_wr) begin
      for (int i = 0; i < 4; i++) begin
        if (req_be[i]) begin
          mem[idx][32*i +: 32] <= req_di[32*i +: 32];
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_d_mem_line_responder.sv
// ---------------------------------------------------------------------------
// tb_d_mem_line_responder : directed scoreboard bench for d_mem_line_responder
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_d_mem_line_responder;

  localparam int AW  = 10;
  localparam int SZ  = 512;
  localparam int LAT = 4;

  logic          CLK  = 1'b0;
  logic          RSTn = 1'b0;
  logic          CSN  = 1'b1;
  logic          WEN  = 1'b1;
  logic [AW-1:0] ADDR = '0;
  logic [127:0]  DI   = '0;
  logic [3:0]    BE   = 4'hF;
  logic [127:0]  DOUT;
  logic          RDY;
  logic          BUSY;

  d_mem_line_responder #(
    .AWIDTH  (AW),
    .SIZE    (SZ),
    .LATENCY (LAT),
    .INITFILE("")
  ) dut (
    .CLK (CLK),
    .RSTn(RSTn),
    .CSN (CSN),
    .WEN (WEN),
    .ADDR(ADDR),
    .DI  (DI),
`ifdef D_MEM_BE_EN
    .BE  (BE),
`endif
    .DOUT(DOUT),
    .RDY (RDY),
    .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  int           total = 0;
  int           bad   = 0;
  logic [127:0] model [int];
  logic [127:0] last_dout = '0;
  logic [127:0] exp_q [$];

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] merge(input logic [127:0] old, input logic [127:0] d,
                                         input logic [3:0] be);
    logic [127:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (be[i]) r[32*i +: 32] = d[32*i +: 32];
    return r;
  endfunction

  // Drive one request, update the model, push the expected DOUT.
  // Returns at the negedge following the accept edge.
  task automatic issue(input logic w, input logic [AW-1:0] a, input logic [127:0] d,
                       input logic [3:0] be);
    logic [3:0]   eff_be;
    logic [127:0] old;
`ifdef D_MEM_BE_EN
    eff_be = be;
`else
    eff_be = 4'hF;
`endif
    @(negedge CLK);
    CSN = 1'b0; WEN = w; ADDR = a; DI = d; BE = be;
    if (w) begin
      last_dout = (int'(a) < SZ) ? model[int'(a)] : '0;
    end else if (int'(a) < SZ) begin
      old = model.exists(int'(a)) ? model[int'(a)] : '0;
      model[int'(a)] = merge(old, d, eff_be);
    end
    exp_q.push_back(last_dout);
    @(posedge CLK);
    @(negedge CLK);
    CSN = 1'b1; WEN = 1'b1;
  endtask

  // Wait (bounded) for RDY, then check latency, BUSY width, DOUT and pulse width.
  task automatic complete(input string tag);
    int           n      = 0;
    int           busy_n = 0;
    bit           seen   = 0;
    logic [127:0] exp;
    while (!seen && n < 40) begin
      if (BUSY) busy_n++;
      @(posedge CLK); n++;
      @(negedge CLK);
      if (RDY) seen = 1;
    end
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
    check({tag, " latency"}, 128'(n), 128'(LAT));
    check({tag, " busy_cycles"}, 128'(busy_n), 128'(LAT));
    check({tag, " dout"}, DOUT, exp);
    check({tag, " busy_end"}, 128'(BUSY), 128'(0));
    @(posedge CLK);
    @(negedge CLK);
    check({tag, " rdy_single"}, 128'(RDY), 128'(0));
  endtask

  localparam logic [127:0] L5 = 128'h0000_0000_0000_0000_0000_0000_0000_0f00;
  localparam logic [127:0] L6 = 128'hDEAD_BEEF_0123_4567_89AB_CDEF_5555_AAAA;
  localparam logic [127:0] L7 = 128'h1111_2222_3333_4444_5555_6666_7777_8888;

  initial begin
    logic [127:0] saved7;
    logic         exp_rdy;

    // Reset behaviour and idle quiet
    repeat (3) @(negedge CLK);
    check("rst dout", DOUT, '0);
    check("rst rdy", 128'(RDY), 128'(0));
    check("rst busy", 128'(BUSY), 128'(0));
    RSTn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      check("idle rdy", 128'(RDY), 128'(0));
      check("idle busy", 128'(BUSY), 128'(0));
    end

    // Basic write then read-back
    issue(1'b0, 10'h005, L5, 4'hF); complete("wr5");
    issue(1'b1, 10'h005, '0, 4'hF); complete("rd5");
    issue(1'b0, 10'h006, L6, 4'hF); complete("wr6");
    issue(1'b1, 10'h006, '0, 4'hF); complete("rd6");

    // CSN held low with alternating ADDR: accepts at relative edges 0, 5, 10
    @(negedge CLK);
    CSN = 1'b0; WEN = 1'b1; ADDR = 10'h005;
    for (int e = 0; e < 15; e++) begin
      if (e == 0 || e == 5 || e == 10) exp_q.push_back(model[(e % 2 == 0) ? 5 : 6]);
      @(posedge CLK);
      @(negedge CLK);
      exp_rdy = (e == 4 || e == 9 || e == 14);
      check("hold rdy", 128'(RDY), 128'(exp_rdy));
      if (RDY) check("hold dout", DOUT, (exp_q.size() > 0) ? exp_q.pop_front() : 'x);
      ADDR = ((e + 1) % 2 == 0) ? 10'h005 : 10'h006;
      if (e == 14) CSN = 1'b1;
    end
    check("hold leftover", 128'(exp_q.size()), 128'(0));
    last_dout = model[5];
    @(negedge CLK);
    check("hold no_extra", 128'(BUSY), 128'(0));

    // Out-of-range access at SIZE
    issue(1'b0, 10'(SZ), L7, 4'hF); complete("wr_oor");
    issue(1'b1, 10'h005, '0, 4'hF); complete("rd5_after_oor");
    issue(1'b1, 10'(SZ), '0, 4'hF); complete("rd_oor");
    issue(1'b1, 10'h3FF, '0, 4'hF); complete("rd_top");

    // Reset during a write: request discarded
    issue(1'b0, 10'h007, L6, 4'hF); complete("wr7_old");
    saved7 = model[7];
    issue(1'b0, 10'h007, L7, 4'hF);
    model[7] = saved7;
    exp_q.delete();
    @(posedge CLK);
    @(negedge CLK);
    @(posedge CLK);
    #2 RSTn = 1'b0;
    #1;
    check("midrst busy", 128'(BUSY), 128'(0));
    check("midrst rdy", 128'(RDY), 128'(0));
    check("midrst dout", DOUT, '0);
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      check("midrst no_rdy", 128'(RDY), 128'(0));
    end
    RSTn = 1'b1;
    last_dout = '0;
    for (int i = 0; i < 6; i++) begin
      @(negedge CLK);
      check("postrst no_rdy", 128'(RDY), 128'(0));
    end
    issue(1'b1, 10'h007, '0, 4'hF); complete("rd7_after_rst");

`ifdef D_MEM_BE_EN
    // Word enables: partial write, and BE=0 no-op
    issue(1'b0, 10'h009, '1, 4'hF); complete("be_fill");
    issue(1'b0, 10'h009, '0, 4'b0101); complete("be_0101");
    issue(1'b1, 10'h009, '0, 4'hF); complete("be_rd");
    check("be_value", DOUT, 128'hFFFFFFFF_00000000_FFFFFFFF_00000000);
    issue(1'b0, 10'h009, L7, 4'b0000); complete("be_none");
    issue(1'b1, 10'h009, '0, 4'b0000); complete("be_rd2");
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
